// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the shared logic unit and its round-robin arbiter.
// Holds the opcode encodings, the arbiter FSM state encoding, and the opcode
// legality check used to flag unsupported operations.
package alu_pkg;

  // Native opcode width of the logic unit.
  localparam int OP_W = 3;

  // Supported opcodes; every other encoding is illegal.
  localparam logic [OP_W-1:0] OP_NOT = 3'b000;
  localparam logic [OP_W-1:0] OP_AND = 3'b001;
  localparam logic [OP_W-1:0] OP_OR  = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;

  // Arbiter FSM states: one operation takes IDLE -> EXEC -> DONE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when the opcode selects one of the four supported operations.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    logic legal_s;
    case (op)
      OP_NOT:  legal_s = 1'b1;
      OP_AND:  legal_s = 1'b1;
      OP_OR:   legal_s = 1'b1;
      OP_XOR:  legal_s = 1'b1;
      default: legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_alu.sv
// alu: combinational bitwise logic unit.
// Ports:
//   a, b     - DW-bit operands
//   opcode   - OPW-bit operation select (NOT A / AND / OR / XOR)
//   alu_out  - DW-bit result; zero for unsupported opcodes
module alu
  import alu_pkg::*;
#(
  parameter int DW  = 4,
  parameter int OPW = 3
) (
  input  logic [DW-1:0]  a,
  input  logic [DW-1:0]  b,
  input  logic [OPW-1:0] opcode,
  output logic [DW-1:0]  alu_out
);

  // Opcode-selected bitwise operation; illegal opcodes yield zero.
  always_comb begin
    alu_out = {DW{1'b0}};
    case (opcode)
      OP_NOT:  alu_out = ~a;
      OP_AND:  alu_out = a & b;
      OP_OR:   alu_out = a | b;
      OP_XOR:  alu_out = a ^ b;
      default: alu_out = {DW{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one logic unit between two requesters with a
// req/done handshake and round-robin fairness.
// Ports:
//   clk, rst_n            - clock (rising edge), async active-low reset
//   req0/op0/a0/b0        - requester 0 request, opcode and operands
//   req1/op1/a1/b1        - requester 1 request, opcode and operands
//   gnt0, gnt1            - owner of the unit during EXEC and DONE
//   done0, done1          - one-cycle pulse: result/err valid for that owner
//   result, err           - registered result and illegal-opcode flag
//   busy                  - an operation is in flight (state != IDLE)
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int DW  = 4,
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0,
  input  logic [OPW-1:0] op0,
  input  logic [DW-1:0]  a0,
  input  logic [DW-1:0]  b0,
  input  logic           req1,
  input  logic [OPW-1:0] op1,
  input  logic [DW-1:0]  a1,
  input  logic [DW-1:0]  b1,
  output logic           gnt0,
  output logic           gnt1,
  output logic           done0,
  output logic           done1,
  output logic [DW-1:0]  result,
  output logic           err,
  output logic           busy
);

  state_e         state_r;
  state_e         state_nxt_s;
  logic           owner_r;       // requester that owns the current operation
  logic           last_gnt_r;    // most recent grant, loses the next tie
  logic           grant_s;
  logic           grant_id_s;
  logic           owner_nxt_s;
  logic [OPW-1:0] op_r;
  logic [DW-1:0]  a_r;
  logic [DW-1:0]  b_r;
  logic [DW-1:0]  alu_out_s;
  logic [DW-1:0]  result_r;
  logic           err_r;
  logic           gnt0_r, gnt1_r, done0_r, done1_r, busy_r;
  logic           gnt0_nxt_s, gnt1_nxt_s, done0_nxt_s, done1_nxt_s, busy_nxt_s;

  // The unit only ever sees latched operands, so requesters may change theirs after grant.
  alu #(
    .DW  (DW),
    .OPW (OPW)
  ) u_alu (
    .a       (a_r),
    .b       (b_r),
    .opcode  (op_r),
    .alu_out (alu_out_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state and grant decision; a tie goes to the requester that did not win last.
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    grant_id_s  = owner_r;
    case (state_r)
      ST_IDLE: begin
        if (req0 && req1) begin
          grant_s    = 1'b1;
          grant_id_s = ~last_gnt_r;
        end else if (req0) begin
          grant_s    = 1'b1;
          grant_id_s = 1'b0;
        end else if (req1) begin
          grant_s    = 1'b1;
          grant_id_s = 1'b1;
        end else begin
          grant_s    = 1'b0;
          grant_id_s = owner_r;
        end
        if (grant_s) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Owner, round-robin history and operand latch, all captured at grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_r    <= 1'b0;
      last_gnt_r <= 1'b1;
      op_r       <= {OPW{1'b0}};
      a_r        <= {DW{1'b0}};
      b_r        <= {DW{1'b0}};
    end else if (grant_s) begin
      owner_r    <= grant_id_s;
      last_gnt_r <= grant_id_s;
      if (grant_id_s) begin
        op_r <= op1;
        a_r  <= a1;
        b_r  <= b1;
      end else begin
        op_r <= op0;
        a_r  <= a0;
        b_r  <= b0;
      end
    end
  end

  // Result and error capture in EXEC; both hold their value until the next EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r <= {DW{1'b0}};
      err_r    <= 1'b0;
    end else if (state_r == ST_EXEC) begin
      result_r <= alu_out_s;
      err_r    <= ~is_legal_op(op_r);
    end
  end

  // Output decode from the upcoming state so the status outputs can be registered.
  always_comb begin
    owner_nxt_s = grant_s ? grant_id_s : owner_r;
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    gnt0_nxt_s  = busy_nxt_s && (owner_nxt_s == 1'b0);
    gnt1_nxt_s  = busy_nxt_s && (owner_nxt_s == 1'b1);
    done0_nxt_s = (state_nxt_s == ST_DONE) && (owner_nxt_s == 1'b0);
    done1_nxt_s = (state_nxt_s == ST_DONE) && (owner_nxt_s == 1'b1);
  end

  // Status output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_r  <= 1'b0;
      gnt1_r  <= 1'b0;
      done0_r <= 1'b0;
      done1_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      gnt0_r  <= gnt0_nxt_s;
      gnt1_r  <= gnt1_nxt_s;
      done0_r <= done0_nxt_s;
      done1_r <= done1_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign gnt0   = gnt0_r;
  assign gnt1   = gnt1_r;
  assign done0  = done0_r;
  assign done1  = done1_r;
  assign busy   = busy_r;
  assign result = result_r;
  assign err    = err_r;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb_alu_rr_arbiter: directed plus randomized self-checking bench for the
// shared logic unit arbiter, checked against a transaction-level reference.
module tb_alu_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, done0, done1, err, busy;
  logic [3:0] result;

  int tests_run;
  int tests_failed;
  int last_w;   // reference model: requester that won most recently

  alu_rr_arbiter #(
    .DW  (4),
    .OPW (3)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req0   (req0),
    .op0    (op0),
    .a0     (a0),
    .b0     (b0),
    .req1   (req1),
    .op1    (op1),
    .a1     (a1),
    .b1     (b1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .done0  (done0),
    .done1  (done1),
    .result (result),
    .err    (err),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: legal opcodes are exactly NOT, AND, OR, XOR.
  function automatic logic ref_legal(input logic [2:0] op);
    return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4);
  endfunction

  // Reference: bitwise result for the operation, zero when illegal.
  function automatic logic [3:0] ref_res(input logic [2:0] op, input logic [3:0] x, input logic [3:0] y);
    if (op == 3'd0) return ~x;
    else if (op == 3'd1) return x & y;
    else if (op == 3'd2) return x | y;
    else if (op == 3'd4) return x ^ y;
    else return 4'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation from IDLE: grant, done, back to IDLE, checked cycle by cycle.
  task automatic do_op(input logic r0, input logic r1,
                       input logic [2:0] o0, input logic [3:0] x0, input logic [3:0] y0,
                       input logic [2:0] o1, input logic [3:0] x1, input logic [3:0] y1);
    int         w;
    logic [3:0] er;
    logic       ee;
    req0 = r0; op0 = o0; a0 = x0; b0 = y0;
    req1 = r1; op1 = o1; a1 = x1; b1 = y1;
    if (r0 && r1) w = (last_w == 0) ? 1 : 0;
    else w = r0 ? 0 : 1;
    if (w == 0) begin
      er = ref_res(o0, x0, y0);
      ee = !ref_legal(o0);
    end else begin
      er = ref_res(o1, x1, y1);
      ee = !ref_legal(o1);
    end
    step();
    chk("exec_gnt0", 32'(gnt0), 32'(w == 0));
    chk("exec_gnt1", 32'(gnt1), 32'(w == 1));
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_nodone", 32'({done0, done1}), 32'd0);
    step();
    chk("done0", 32'(done0), 32'(w == 0));
    chk("done1", 32'(done1), 32'(w == 1));
    chk("done_result", 32'(result), 32'(er));
    chk("done_err", 32'(err), 32'(ee));
    chk("done_busy", 32'(busy), 32'd1);
    chk("done_gnt", 32'({gnt1, gnt0}), (w == 0) ? 32'd1 : 32'd2);
    if (w == 0) req0 = 1'b0;
    else req1 = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_gnt", 32'({gnt0, gnt1}), 32'd0);
    chk("idle_done", 32'({done0, done1}), 32'd0);
    chk("idle_hold", 32'(result), 32'(er));
    last_w = w;
  endtask

  initial begin
    logic [1:0] r;
    tests_run = 0;
    tests_failed = 0;
    last_w = 1;
    rst_n = 1'b0;
    req0 = 1'b0; op0 = 3'd0; a0 = 4'd0; b0 = 4'd0;
    req1 = 1'b0; op1 = 3'd0; a1 = 4'd0; b1 = 4'd0;
    step();
    step();
    chk("rst_outs", 32'({gnt0, gnt1, done0, done1, err, busy}), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Single requester 0: AND.
    do_op(1'b1, 1'b0, 3'b001, 4'b0110, 4'b0101, 3'd0, 4'd0, 4'd0);
    // Single requester 1: NOT, then XOR.
    do_op(1'b0, 1'b1, 3'd0, 4'd0, 4'd0, 3'b000, 4'b0110, 4'b0000);
    do_op(1'b0, 1'b1, 3'd0, 4'd0, 4'd0, 3'b100, 4'b0110, 4'b0101);
    // Continuous contention: alternating grants starting with requester 0.
    for (int i = 0; i < 4; i++) begin
      do_op(1'b1, 1'b1, 3'b010, 4'b0110, 4'b0101, 3'b100, 4'b0110, 4'b0101);
      chk("rr_order", 32'(last_w), 32'(i % 2));
    end
    // Illegal opcode, then a legal one clears err.
    do_op(1'b1, 1'b0, 3'b011, 4'b1111, 4'b1111, 3'd0, 4'd0, 4'd0);
    do_op(1'b1, 1'b0, 3'b100, 4'b1010, 4'b0110, 3'd0, 4'd0, 4'd0);

    // Operand change and req drop during EXEC do not disturb the operation.
    req0 = 1'b1; op0 = 3'b010; a0 = 4'b0011; b0 = 4'b0100; req1 = 1'b0;
    step();
    chk("chg_gnt0", 32'(gnt0), 32'd1);
    a0 = 4'b1111;
    req0 = 1'b0;
    step();
    chk("chg_done0", 32'(done0), 32'd1);
    chk("chg_result", 32'(result), 32'(4'b0111));
    step();
    chk("chg_idle", 32'(busy), 32'd0);
    last_w = 0;

    // Randomized traffic against the reference model.
    for (int i = 0; i < 30; i++) begin
      r = 2'($urandom_range(1, 3));
      do_op(r[0], r[1],
            3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
            3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
    end

    // Reset during EXEC aborts the operation immediately.
    req0 = 1'b1; op0 = 3'b001; a0 = 4'b1111; b0 = 4'b1010; req1 = 1'b0;
    step();
    chk("pre_abort_gnt0", 32'(gnt0), 32'd1);
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("abort_outs", 32'({gnt0, gnt1, done0, done1, err, busy}), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    step();
    chk("abort_nodone", 32'({done0, done1}), 32'd0);
    rst_n = 1'b1;
    step();
    chk("abort_idle", 32'({busy, done0, done1}), 32'd0);
    last_w = 1;
    do_op(1'b1, 1'b1, 3'b000, 4'b0101, 4'd0, 3'b001, 4'b1111, 4'b1111);
    chk("post_abort_first", 32'(last_w), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
